// File: rtl/spy_snapshot.sv
// ---------------------------------------------------------------------------
// spy_snapshot
//
// Spy-bus examine unit for the debug interface. On every state-advance strobe
// it captures NCHAN processor-state words of DW bits. Through an 8-bit spy
// address it presents any 16-bit slice of that snapshot, of the live channel
// data, or of an optional trace FIFO that records one channel per capture.
//
// Address map (P = DW/16 slices per channel, slice 0 = bits [15:0]):
//   0x00 + A       snapshot word A  (channel A/P, slice A%P), A < NCHAN*P
//   0x40 + A       the same slice taken live from chan_in
//   0xC0 + s       slice s of the trace FIFO head entry (0xFFFF when empty)
//   0xFE           trace status {trace_ovf, 0..., trace_count}
//   anything else  0xFFFF
// A read completes on the falling edge of dbread. Completing at 0xC0+(P-1)
// pops the FIFO head; completing at 0xFE clears trace_ovf.
//
// Configuration macro: SPY_TRACE_EN builds the trace FIFO. Without it the
// FIFO addresses read 0xFFFF and trace_count / trace_ovf are tied to 0.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   state_write  state-advance strobe, one capture per high cycle
//   freeze       blocks snapshot update and trace push
//   chan_in      live channel data, channel k = chan_in[k*DW +: DW]
//   spy_addr     spy word select
//   dbread       spy read strobe (level)
//   spy_out      registered spy read data
//   trace_count  trace FIFO occupancy
//   trace_ovf    sticky trace-overflow flag
// ---------------------------------------------------------------------------
module spy_snapshot #(
   parameter int NCHAN      = 8,
   parameter int DW         = 32,
   parameter int DEPTH      = 16,
   parameter int TRACE_CHAN = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     state_write,
   input  logic                     freeze,
   input  logic [NCHAN*DW-1:0]      chan_in,
   input  logic [7:0]               spy_addr,
   input  logic                     dbread,
   output logic [15:0]              spy_out,
   output logic [$clog2(DEPTH):0]   trace_count,
   output logic                     trace_ovf
);

   localparam int P  = DW / 16;
   localparam int NW = NCHAN * P;
   localparam int AW = $clog2(DEPTH);

   // Elaboration-time parameter sanity checks.
   if (DW < 16 || DW > 64 || (DW % 16) != 0) begin : g_bad_dw
      $error("spy_snapshot: DW must be a multiple of 16 between 16 and 64");
   end
   if (NW > 64) begin : g_bad_nw
      $error("spy_snapshot: NCHAN*DW/16 must not exceed 64");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("spy_snapshot: DEPTH must be a power of 2 and at least 2");
   end
   if (TRACE_CHAN < 0 || TRACE_CHAN >= NCHAN) begin : g_bad_trace_chan
      $error("spy_snapshot: TRACE_CHAN must be below NCHAN");
   end

   // A capture (snapshot update and trace push) happens on every unfrozen strobe.
   logic capture;
   assign capture = state_write & ~freeze;

   // ------------------------------------------------------------------------
   // Snapshot register, held as 16-bit words so word A is simply snap_q[A].
   // ------------------------------------------------------------------------
   logic [15:0] snap_q [NW];

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking (=) is kept for always_comb only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int w = 0; w < NW; w++) snap_q[w] <= '0;
      end else if (capture) begin
         for (int w = 0; w < NW; w++) snap_q[w] <= chan_in[w*16 +: 16];
      end
   end

   // ------------------------------------------------------------------------
   // Snapshot / live word select on the low 6 address bits.
   // ------------------------------------------------------------------------
   logic [15:0] snap_word;
   logic [15:0] live_word;
   logic [15:0] trace_word;
   logic [15:0] rd_word;

   // NOTE: every always_comb output gets a default first, so no path through
   // the block leaves it unassigned and no latch is inferred.
   always_comb begin
      snap_word = 16'hFFFF;
      live_word = 16'hFFFF;
      for (int w = 0; w < NW; w++) begin
         if (spy_addr[5:0] == 6'(w)) begin
            snap_word = snap_q[w];
            live_word = chan_in[w*16 +: 16];
         end
      end
   end

   always_comb begin
      unique case (spy_addr[7:6])
         2'b00:   rd_word = snap_word;
         2'b01:   rd_word = live_word;
         2'b11:   rd_word = trace_word;
         default: rd_word = 16'hFFFF;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) spy_out <= 16'hFFFF;
      else       spy_out <= dbread ? rd_word : 16'hFFFF;
   end

`ifdef SPY_TRACE_EN
   // ------------------------------------------------------------------------
   // Read completion: falling edge of dbread, qualified by the address that
   // was presented while dbread was still high. The decoded completion is
   // registered and acted on at the following edge.
   // ------------------------------------------------------------------------
   localparam int              HEAD_BASE   = 8'hC0;
   localparam logic [7:0]      HEAD_LAST   = 8'(HEAD_BASE + P - 1);
   localparam logic [7:0]      STATUS_ADDR = 8'hFE;
   localparam logic [AW:0]     FULL_COUNT  = (AW+1)'(DEPTH);

   logic       dbread_q;
   logic [7:0] addr_q;
   logic       pop_q;
   logic       clr_q;
   logic       read_done;

   assign read_done = dbread_q & ~dbread;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dbread_q <= 1'b0;
         addr_q   <= '0;
         pop_q    <= 1'b0;
         clr_q    <= 1'b0;
      end else begin
         dbread_q <= dbread;
         addr_q   <= spy_addr;
         pop_q    <= read_done & (addr_q == HEAD_LAST);
         clr_q    <= read_done & (addr_q == STATUS_ADDR);
      end
   end

   // ------------------------------------------------------------------------
   // Trace FIFO. When full, a push overwrites the oldest entry (tail == head)
   // and drags head along with it, unless a pop frees the slot that cycle.
   // ------------------------------------------------------------------------
   logic [DW-1:0] fifo_mem [DEPTH];
   logic [AW-1:0] head_q;
   logic [AW-1:0] tail_q;
   logic [AW:0]   count_q;
   logic          ovf_q;
   logic          fifo_empty;
   logic          fifo_full;
   logic          pop_ok;
   logic          overwrite;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FULL_COUNT);
   assign pop_ok     = pop_q & ~fifo_empty;
   assign overwrite  = capture & fifo_full & ~pop_ok;

   // NOTE: the storage array has no reset; occupancy gates every read of it,
   // so stale contents are never visible and the array stays plain RAM.
   always_ff @(posedge clk) begin
      if (capture) fifo_mem[tail_q] <= chan_in[TRACE_CHAN*DW +: DW];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (capture) tail_q <= tail_q + 1'b1;
         if (pop_ok || overwrite) head_q <= head_q + 1'b1;

         if (capture && !pop_ok && !fifo_full) count_q <= count_q + 1'b1;
         else if (pop_ok && !capture)          count_q <= count_q - 1'b1;

         // Set has priority over a same-cycle clear.
         ovf_q <= overwrite | (ovf_q & ~clr_q);
      end
   end

   logic [DW-1:0] head_entry;
   logic [15:0]   status_word;

   assign head_entry = fifo_mem[head_q];

   always_comb begin
      status_word        = '0;
      status_word[AW:0]  = count_q;
      status_word[15]    = ovf_q;
   end

   always_comb begin
      trace_word = 16'hFFFF;
      if (spy_addr == STATUS_ADDR) begin
         trace_word = status_word;
      end else if (!fifo_empty) begin
         for (int s = 0; s < P; s++) begin
            if (spy_addr == 8'(HEAD_BASE + s)) trace_word = head_entry[s*16 +: 16];
         end
      end
   end

   assign trace_count = count_q;
   assign trace_ovf   = ovf_q;
`else
   // Trace FIFO not built: its addresses read as unmapped.
   assign trace_word  = 16'hFFFF;
   assign trace_count = '0;
   assign trace_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_spy_snapshot.sv
// ---------------------------------------------------------------------------
// Self-checking bench for spy_snapshot (defaults NCHAN=8, DW=32, DEPTH=16,
// TRACE_CHAN=0). A behavioural model keeps the snapshot as channel words and
// the trace FIFO as a bounded queue; expected spy data, occupancy and the
// overflow flag come from that model. Trace scenarios are compiled only when
// SPY_TRACE_EN is defined; otherwise the unmapped behaviour is checked.
// ---------------------------------------------------------------------------
module tb_spy_snapshot;

   localparam int NCHAN = 8;
   localparam int DW    = 32;
   localparam int DEPTH = 16;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   state_write;
   logic                   freeze;
   logic [NCHAN*DW-1:0]    chan_in;
   logic [7:0]             spy_addr;
   logic                   dbread;
   logic [15:0]            spy_out;
   logic [$clog2(DEPTH):0] trace_count;
   logic                   trace_ovf;

   int tests_run    = 0;
   int tests_failed = 0;

   spy_snapshot #(
      .NCHAN(NCHAN), .DW(DW), .DEPTH(DEPTH), .TRACE_CHAN(0)
   ) dut (
      .clk(clk), .reset(reset), .state_write(state_write), .freeze(freeze),
      .chan_in(chan_in), .spy_addr(spy_addr), .dbread(dbread),
      .spy_out(spy_out), .trace_count(trace_count), .trace_ovf(trace_ovf)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [31:0] m_snap [NCHAN];
   logic [15:0] exp_spy;
   bit          m_ovf;
`ifdef SPY_TRACE_EN
   logic [31:0] m_q [$];
   bit          m_dbq;
   logic [7:0]  m_addr_q;
   bit          m_pop_pend;
   bit          m_clr_pend;
`endif

   function automatic int model_count();
`ifdef SPY_TRACE_EN
      return m_q.size();
`else
      return 0;
`endif
   endfunction

   // Word visible at address a, given the model state before the edge.
   function automatic logic [15:0] model_word(input logic [7:0] a);
      logic [31:0] w;
      int          idx;
      if (a < 8'd16) begin
         w = m_snap[int'(a) / 2];
         return (a % 2 == 1) ? w[31:16] : w[15:0];
      end
      if (a >= 8'h40 && a < 8'h50) begin
         idx = int'(a) - 64;
         w = chan_in[(idx / 2) * 32 +: 32];
         return (idx % 2 == 1) ? w[31:16] : w[15:0];
      end
`ifdef SPY_TRACE_EN
      if (a == 8'hC0 || a == 8'hC1) begin
         if (m_q.size() == 0) return 16'hFFFF;
         w = m_q[0];
         return (a == 8'hC1) ? w[31:16] : w[15:0];
      end
      if (a == 8'hFE) return {m_ovf, 10'b0, 5'(m_q.size())};
`endif
      return 16'hFFFF;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCHAN; c++) m_snap[c] = '0;
      m_ovf = 1'b0;
`ifdef SPY_TRACE_EN
      m_q.delete();
      m_dbq      = 1'b0;
      m_addr_q   = '0;
      m_pop_pend = 1'b0;
      m_clr_pend = 1'b0;
`endif
   endtask

   // Advance one clock with the inputs currently driven, updating the model
   // with the effect of that edge. Returns #1 after the edge.
   task automatic step();
      bit push;
      push    = state_write && !freeze;
      exp_spy = dbread ? model_word(spy_addr) : 16'hFFFF;
`ifdef SPY_TRACE_EN
      begin
         bit fall;
         fall = m_dbq && !dbread;
         if (m_clr_pend) m_ovf = 1'b0;
         if (m_pop_pend && m_q.size() != 0) void'(m_q.pop_front());
         if (push) begin
            m_q.push_back(chan_in[31:0]);
            if (m_q.size() > DEPTH) begin
               void'(m_q.pop_front());
               m_ovf = 1'b1;
            end
         end
         m_pop_pend = fall && (m_addr_q == 8'hC1);
         m_clr_pend = fall && (m_addr_q == 8'hFE);
         m_dbq      = dbread;
         m_addr_q   = spy_addr;
      end
`endif
      if (push) for (int c = 0; c < NCHAN; c++) m_snap[c] = chan_in[c*32 +: 32];
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_chan();
      for (int c = 0; c < NCHAN; c++) chan_in[c*32 +: 32] = $urandom;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      state_write = 1'b0; freeze = 1'b0; dbread = 1'b0; spy_addr = '0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      state_write = 1'b0; freeze = 1'b0; dbread = 1'b0; spy_addr = '0;
      chan_in = '0;
      model_reset();
      #3;
      tests_run++;
      if (spy_out !== 16'hFFFF) begin
         tests_failed++; $display("FAIL reset_spy_out: got %h expected ffff", spy_out);
      end
      tests_run++;
      if (trace_count !== '0) begin
         tests_failed++; $display("FAIL reset_count: got %0d expected 0", trace_count);
      end
      tests_run++;
      if (trace_ovf !== 1'b0) begin
         tests_failed++; $display("FAIL reset_ovf: got %b expected 0", trace_ovf);
      end
      @(negedge clk);
      reset = 1'b0;
      randomize_chan();
      dbread = 1'b1; spy_addr = 8'h05;
      step();
      tests_run++;
      if (spy_out !== 16'h0000) begin
         tests_failed++; $display("FAIL reset_snap_zero: got %h expected 0000", spy_out);
      end
   endtask

   task automatic test_snapshot();
      randomize_chan();
      chan_in[3*32 +: 32] = 32'h1234_5678;
      dbread = 1'b0; state_write = 1'b1;
      step();
      state_write = 1'b0;
      randomize_chan();
      dbread = 1'b1; spy_addr = 8'h06;
      step();
      tests_run++;
      if (spy_out !== 16'h5678 || spy_out !== exp_spy) begin
         tests_failed++; $display("FAIL snap_lo: got %h expected 5678 (model %h)", spy_out, exp_spy);
      end
      spy_addr = 8'h07;
      step();
      tests_run++;
      if (spy_out !== 16'h1234 || spy_out !== exp_spy) begin
         tests_failed++; $display("FAIL snap_hi: got %h expected 1234 (model %h)", spy_out, exp_spy);
      end
   endtask

   task automatic test_freeze();
      logic [15:0] live_lo;
      freeze = 1'b1; dbread = 1'b0;
      for (int i = 0; i < 3; i++) begin
         randomize_chan();
         chan_in[3*32 +: 16] = 16'hA5A0 + 16'(i);
         state_write = 1'b1;
         step();
      end
      freeze = 1'b0; state_write = 1'b0;
      dbread = 1'b1; spy_addr = 8'h06;
      step();
      tests_run++;
      if (spy_out !== 16'h5678 || spy_out !== exp_spy) begin
         tests_failed++; $display("FAIL freeze_hold: got %h expected 5678 (model %h)", spy_out, exp_spy);
      end
      live_lo = chan_in[3*32 +: 16];
      spy_addr = 8'h46;
      step();
      tests_run++;
      if (spy_out !== live_lo || spy_out !== exp_spy) begin
         tests_failed++; $display("FAIL live_lo: got %h expected %h", spy_out, live_lo);
      end
   endtask

   task automatic test_unmapped();
      logic [7:0] addrs [4];
      addrs[0] = 8'h06; addrs[1] = 8'h10; addrs[2] = 8'hFD; addrs[3] = 8'h50;
      for (int i = 0; i < 4; i++) begin
         dbread   = (i != 0);
         spy_addr = addrs[i];
         step();
         tests_run++;
         if (spy_out !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL unmapped_%0d: addr %h dbread %b got %h expected ffff", i, addrs[i], dbread, spy_out);
         end
      end
      dbread = 1'b0;
      step();
   endtask

`ifdef SPY_TRACE_EN
   task automatic test_trace_overflow();
      do_reset();
      for (int i = 1; i <= 20; i++) begin
         chan_in = '0;
         chan_in[31:0] = 32'(i);
         state_write = 1'b1;
         step();
      end
      state_write = 1'b0;
      tests_run++;
      if (trace_count !== 5'd16 || trace_ovf !== 1'b1) begin
         tests_failed++; $display("FAIL trace_fill: got count %0d ovf %b expected 16 1", trace_count, trace_ovf);
      end
      dbread = 1'b1; spy_addr = 8'hC0;
      step();
      tests_run++;
      if (spy_out !== 16'h0005 || spy_out !== exp_spy) begin
         tests_failed++; $display("FAIL trace_head: got %h expected 0005", spy_out);
      end
      spy_addr = 8'hFE;
      step();
      tests_run++;
      if (spy_out !== 16'h8010 || spy_out !== exp_spy) begin
         tests_failed++; $display("FAIL trace_status: got %h expected 8010", spy_out);
      end
      spy_addr = 8'hC1;
      step();
      dbread = 1'b0;
      step();
      tests_run++;
      if (trace_count !== 5'd16) begin
         tests_failed++; $display("FAIL pop_latency: got %0d expected 16", trace_count);
      end
      step();
      tests_run++;
      if (trace_count !== 5'd15) begin
         tests_failed++; $display("FAIL pop_count: got %0d expected 15", trace_count);
      end
      dbread = 1'b1; spy_addr = 8'hC0;
      step();
      tests_run++;
      if (spy_out !== 16'h0006 || spy_out !== exp_spy) begin
         tests_failed++; $display("FAIL pop_head: got %h expected 0006", spy_out);
      end
      // Complete a status read: overflow clears.
      spy_addr = 8'hFE;
      step();
      dbread = 1'b0;
      step();
      step();
      tests_run++;
      if (trace_ovf !== 1'b0 || trace_ovf !== m_ovf) begin
         tests_failed++; $display("FAIL ovf_clear: got %b expected 0", trace_ovf);
      end
   endtask

   task automatic test_push_pop_full();
      chan_in = '0; chan_in[31:0] = 32'd21;
      state_write = 1'b1;
      step();
      state_write = 1'b0;
      dbread = 1'b1; spy_addr = 8'hC1;
      step();
      dbread = 1'b0;
      step();
      chan_in[31:0] = 32'd22;
      state_write = 1'b1;
      step();
      state_write = 1'b0;
      tests_run++;
      if (trace_count !== 5'd16 || trace_ovf !== 1'b0 || 32'(trace_count) !== model_count()) begin
         tests_failed++; $display("FAIL push_pop_full: got count %0d ovf %b expected 16 0", trace_count, trace_ovf);
      end
      dbread = 1'b1; spy_addr = 8'hC0;
      step();
      tests_run++;
      if (spy_out !== 16'h0007 || spy_out !== exp_spy) begin
         tests_failed++; $display("FAIL push_pop_head: got %h expected 0007", spy_out);
      end
      dbread = 1'b0;
      step();
   endtask
`endif

   task automatic test_reset_mid_read();
      do_reset();
      for (int i = 0; i < 7; i++) begin
         randomize_chan();
         state_write = 1'b1;
         step();
      end
      state_write = 1'b0;
      tests_run++;
      if (32'(trace_count) !== model_count()) begin
         tests_failed++; $display("FAIL pre_reset_count: got %0d expected %0d", trace_count, model_count());
      end
      dbread = 1'b1; spy_addr = 8'hC0;
      step();
      #3;
      reset = 1'b1;
      model_reset();
      #1;
      tests_run++;
      if (spy_out !== 16'hFFFF || trace_count !== '0 || trace_ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_read_reset: got spy %h count %0d ovf %b expected ffff 0 0", spy_out, trace_count, trace_ovf);
      end
      @(negedge clk);
      reset = 1'b0;
      spy_addr = 8'h06;
      step();
      tests_run++;
      if (spy_out !== 16'h0000) begin
         tests_failed++; $display("FAIL post_reset_snap: got %h expected 0000", spy_out);
      end
      dbread = 1'b0;
      step();
   endtask

   task automatic test_trace_addresses();
      // With the FIFO built these come from the model; without it they are unmapped.
      logic [7:0] addrs [3];
      addrs[0] = 8'hC0; addrs[1] = 8'hC1; addrs[2] = 8'hFE;
      randomize_chan();
      state_write = 1'b1;
      step();
      state_write = 1'b0;
      for (int i = 0; i < 3; i++) begin
         dbread = 1'b1; spy_addr = addrs[i];
         step();
         tests_run++;
         if (spy_out !== exp_spy) begin
            tests_failed++; $display("FAIL trace_addr_%h: got %h expected %h", addrs[i], spy_out, exp_spy);
         end
`ifndef SPY_TRACE_EN
         tests_run++;
         if (spy_out !== 16'hFFFF || trace_count !== '0 || trace_ovf !== 1'b0) begin
            tests_failed++; $display("FAIL no_trace_%h: got %h count %0d ovf %b expected ffff 0 0", addrs[i], spy_out, trace_count, trace_ovf);
         end
`endif
      end
      dbread = 1'b0;
      step();
   endtask

   task automatic test_random();
      logic [7:0] a;
      for (int cyc = 0; cyc < 400; cyc++) begin
         randomize_chan();
         state_write = ($urandom_range(2) == 0);
         freeze      = ($urandom_range(4) == 0);
         if ($urandom_range(2) == 0) dbread = ~dbread;
         case ($urandom_range(7))
            0, 1:    a = 8'($urandom_range(15));
            2:       a = 8'h40 + 8'($urandom_range(15));
            3:       a = 8'hC0;
            4:       a = 8'hC1;
            5:       a = 8'hFE;
            6:       a = 8'($urandom_range(255));
            default: a = 8'h10;
         endcase
         if (!(dbread && $urandom_range(3) != 0)) spy_addr = a;
         step();
         tests_run++;
         if (spy_out !== exp_spy || 32'(trace_count) !== model_count() || trace_ovf !== m_ovf) begin
            tests_failed++;
            $display("FAIL random_%0d: got spy %h count %0d ovf %b expected %h %0d %b",
                     cyc, spy_out, trace_count, trace_ovf, exp_spy, model_count(), m_ovf);
         end
      end
      state_write = 1'b0; freeze = 1'b0; dbread = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_snapshot();
      test_freeze();
      test_unmapped();
`ifdef SPY_TRACE_EN
      test_trace_overflow();
      test_push_pop_full();
`endif
      test_trace_addresses();
      test_reset_mid_read();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/spy_snapshot.md
# spy_snapshot

Parametrised spy-bus examine unit for the debug interface. It captures NCHAN processor-state words of DW bits on each state-advance strobe, generalising the single last-cycle OB latch. It presents any 16-bit slice of snapshot or live data to the PDP-11 spy port through an 8-bit address, replacing the fixed select-line mux. An optional trace FIFO records one chosen channel every cycle for post-halt readback.

## Interface
- NCHAN, 8: number of monitored channels; NCHAN*(DW/16) ≤ 64.
- DW, 32: channel width; multiple of 16, ≤ 64. P = DW/16 slices per channel.
- DEPTH, 16: trace FIFO entries; power of 2, ≥ 2.
- TRACE_CHAN, 0: channel index recorded by the trace FIFO; < NCHAN.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- state_write  in  1  processor state-advance strobe; one capture per high cycle.
- freeze  in  1  when high, blocks snapshot update and trace push.
- chan_in  in  NCHAN*DW  live channel data; channel k is chan_in[k*DW +: DW].
- spy_addr  in  8  spy word select.
- dbread  in  1  spy read strobe, level; may be held high for several cycles.
- spy_out  out  16  registered spy read data.
- trace_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- trace_ovf  out  1  sticky trace-overflow flag.

## Operation
- Snapshot: when state_write=1 and freeze=0, snap[k] <= chan_in slice k for all k. Otherwise snap holds.
- Address map:
  - A < NCHAN*P: snapshot. Channel A/P, slice A%P, where slice 0 is bits [15:0].
  - 0x40+A with A < NCHAN*P: the same slice, taken live from chan_in.
  - 0xC0+s with s < P: slice s of the FIFO head entry.
  - 0xFE: trace status {trace_ovf, 0…, trace_count} zero-extended to 16 bits, ovf in bit 15.
  - Any other address reads 0xFFFF.
- Read: each cycle, spy_out <= dbread ? word(spy_addr) : 0xFFFF.
- Read completion is the falling edge of dbread, detected with a registered copy of dbread (dbread_q=1, dbread=0). The address used is the one registered with dbread_q.
  - Completion at 0xC0+(P-1): pop the FIFO head.
  - Completion at 0xFE: clear trace_ovf.
- Trace push: same condition as the snapshot update. The entry is chan_in channel TRACE_CHAN.
- Full push with no pop: overwrite the oldest entry, advance head, count stays DEPTH, set trace_ovf.
- Push and pop in the same cycle: full → head advances, new entry written, count unchanged, no overflow. Empty → the push alone takes effect and count=1.
- Pop when empty: ignored; count stays 0, pointers unchanged.
- Head read when empty: 0xFFFF.
- Overflow set and clear in the same cycle: set wins.
- Pointers wrap modulo DEPTH and are $clog2(DEPTH) bits wide. Count saturates at DEPTH.

## Timing
- spy_out: 1-cycle latency from spy_addr/dbread. Live reads reflect chan_in sampled at that edge.
- Snapshot is visible through spy_out 2 cycles after the state_write edge: the capture edge, then the output register.
- A pop is visible in trace_count on the edge after the dbread fall is detected, i.e. 2 edges after dbread drops.
- Reset (asynchronous, any time, including mid-read): spy_out=0xFFFF, snap=0, dbread_q=0, FIFO pointers=0, trace_count=0, trace_ovf=0.
- FIFO storage is not reset, but empty reads return 0xFFFF, so storage contents are never exposed.

## Configuration
- SPY_TRACE_EN defined: the trace FIFO, the 0xC0+s and 0xFE addresses, trace_count and trace_ovf are all present as described.
- SPY_TRACE_EN undefined: no FIFO storage or pointers are built.
  - 0xC0+s and 0xFE read 0xFFFF.
  - trace_count is tied to 0 and trace_ovf to 0.
  - Snapshot and live paths are unchanged.

## Test plan
- Defaults (NCHAN=8, DW=32). chan_in channel 3 = 0x1234_5678, one state_write pulse, then dbread with addr 0x06 then 0x07 → spy_out 0x5678, then 0x1234.
- freeze=1 with state_write pulses while chan_in changes → addr 0x06 still reads 0x5678. addr 0x46 reads the new live low slice.
- dbread=0, or addr 0x10/0xFD → spy_out=0xFFFF on the following cycle.
- Trace, DEPTH=16: 20 pushes of channel 0 values 1..20 → trace_count=16, trace_ovf=1. 0xC0 reads 0x0005. Complete a read at 0xC1 → count 15, head 6.
- Status: read 0xFE → 0x8010; complete that read → trace_ovf=0. Push and pop in the same cycle while full → count stays 16, trace_ovf stays 0.
- Assert reset mid-read with FIFO at count 7 → spy_out=0xFFFF, count=0, snapshot reads 0x0000. Rebuild without SPY_TRACE_EN → 0xFE reads 0xFFFF.
